// File: rtl/id_decode_queue.sv
// ID stage: decodes a 9-instruction LA32R subset into a packed control word and
// buffers the results in a small FIFO between IF (left side) and EXE (right side).
module id_decode_queue #(
  parameter int DEPTH    = 2,
  parameter int ALU_OP_W = 14,
  parameter int CTRL_W   = 1 + ALU_OP_W + 1 + 32 + 32 + 5 + 1 + 32 + 32 + 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic [31:0]       PC,
  input  logic              left_valid,
  output logic              left_ready,
  input  logic              flush,
  output logic [4:0]        reg_index1,
  output logic [4:0]        reg_index2,
  input  logic [31:0]       reg_data1,
  input  logic [31:0]       reg_data2,
  output logic              right_valid,
  input  logic              right_ready,
  output logic [CTRL_W-1:0] ctrl_bus
);

  // DEPTH must be a power of two so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------- decode
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;

  logic is_add, is_sub, is_slt, is_and, is_or;
  logic is_addi, is_ori, is_lu12i, is_pcadd;
  logic is_rtype, inst_valid, is_sign, wreg_en;

  logic [ALU_OP_W-1:0] alu_op;
  logic [31:0]         imm;
  logic [31:0]         src1;
  logic [31:0]         src2;
  logic [4:0]          wreg_index;

  assign op17 = Inst[31:15];
  assign op10 = Inst[31:22];
  assign op7  = Inst[31:25];

  assign is_add   = (op17 == 17'h00020);
  assign is_sub   = (op17 == 17'h00022);
  assign is_slt   = (op17 == 17'h00024);
  assign is_and   = (op17 == 17'h00029);
  assign is_or    = (op17 == 17'h0002A);
  assign is_addi  = (op10 == 10'h00A);
  assign is_ori   = (op10 == 10'h00E);
  assign is_lu12i = (op7  == 7'h0A);
  assign is_pcadd = (op7  == 7'h0E);

  assign is_rtype   = is_add | is_sub | is_slt | is_and | is_or;
  assign inst_valid = is_rtype | is_addi | is_ori | is_lu12i | is_pcadd;
  assign is_sign    = is_slt;

  assign reg_index1 = Inst[9:5];
  assign reg_index2 = Inst[14:10];
  assign wreg_index = Inst[4:0];
  assign wreg_en    = inst_valid & (wreg_index != 5'd0);

  // An illegal encoding matches no decode term, so op/imm/src all fall to zero.
  always_comb begin
    alu_op    = '0;
    alu_op[0] = is_add | is_addi | is_lu12i | is_pcadd;
    alu_op[1] = is_sub;
    alu_op[2] = is_slt;
    alu_op[3] = is_and;
    alu_op[4] = is_or | is_ori;

    imm = 32'h0;
    if (is_addi) begin
      imm = {{20{Inst[21]}}, Inst[21:10]};
    end else if (is_ori) begin
      imm = {20'h0, Inst[21:10]};
    end else if (is_lu12i | is_pcadd) begin
      imm = {Inst[24:5], 12'h0};
    end

    src1 = 32'h0;
    if (is_rtype | is_addi | is_ori) begin
      src1 = reg_data1;
    end else if (is_pcadd) begin
      src1 = PC;
    end

    src2 = is_rtype ? reg_data2 : imm;
  end

  logic [CTRL_W-1:0] entry_d;
  assign entry_d = {is_sign, alu_op, inst_valid, PC, Inst,
                    wreg_index, wreg_en, src2, src1, imm};

  // ---------------------------------------------------------------- queue
  logic              reset_n_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CTRL_W-1:0] mem_q [DEPTH];

  logic push, pop, wr_en;
  logic [DEPTH-1:0] slot_we;

  assign left_ready  = (count_q != CNT_W'(DEPTH)) & reset_n_q;
  assign right_valid = (count_q != '0);
  assign push        = left_valid & left_ready;
  assign pop         = right_valid & right_ready;
  // A push coinciding with flush is discarded; the pop still completes.
  assign wr_en       = push & ~flush;

  assign ctrl_bus = right_valid ? mem_q[rd_ptr_q] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = wr_en && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reset_n_q <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      reset_n_q <= 1'b1;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        mem_q[i] <= '0;
      end else if (slot_we[i]) begin
        mem_q[i] <= entry_d;
      end
    end
  end

endmodule
